// File: rtl/rip_csr_trap_unit_if.sv
// rip_csr_trap_unit_if: decode/execute <-> CSR/trap unit bus.
//   master (pipeline side): drives CSR access, exceptions, mret; receives read data and redirect.
//   slave  (rip_csr_trap_unit): the opposite directions.
interface rip_csr_trap_unit_if;
    logic        csr_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] inst_pc;
    logic        exc_illegal;
    logic        exc_ecall;
    logic        mret;
    logic [31:0] csr_rdata;
    logic        csr_rdata_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    modport master (
        output csr_valid, csr_op, csr_addr, csr_wdata, inst_pc, exc_illegal, exc_ecall, mret,
        input  csr_rdata, csr_rdata_valid, redirect_valid, redirect_pc, busy
    );
    modport slave (
        input  csr_valid, csr_op, csr_addr, csr_wdata, inst_pc, exc_illegal, exc_ecall, mret,
        output csr_rdata, csr_rdata_valid, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/rip_csr_trap_unit.sv
// rip_csr_trap_unit: machine-mode CSR file (mtvec/mepc/mcause) and trap/mret sequencer.
//   clk, rstn (synchronous, active-low), bus (rip_csr_trap_unit_if.slave).
//   Optional 64-bit mcycle counter at 0xB00/0xB80 when RIP_CSR_MCYCLE_EN is defined.
module rip_csr_trap_unit #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic              clk,
    input logic              rstn,
    rip_csr_trap_unit_if.slave bus
);
    localparam logic [11:0] MTVEC   = 12'h305;
    localparam logic [11:0] MEPC    = 12'h341;
    localparam logic [11:0] MCAUSE  = 12'h342;
    localparam logic [31:0] CAUSE_ILLEGAL_INST = 32'd2;
    localparam logic [31:0] CAUSE_ECALL        = 32'd11;
    typedef enum logic {RUN, FLUSH} state_e;
    state_e      state_q;
    logic [31:0] mtvec_q, mepc_q, mcause_q, csr_rdata_q, redirect_pc_q;
    logic        csr_rdata_valid_q, redirect_valid_q;
    logic [31:0] old_val, new_val;
    logic        access, impl, run, take_ill, take_ecall, take_mret, take_csr, wr;
`ifdef RIP_CSR_MCYCLE_EN
    localparam logic [11:0] MCYCLE  = 12'hB00;
    localparam logic [11:0] MCYCLEH = 12'hB80;
    logic [63:0] mcycle_q, mcycle_d;
`endif
    always_comb begin
        access  = bus.csr_valid && (bus.csr_op != 2'b00);
        old_val = (bus.csr_addr == MTVEC) ? mtvec_q : (bus.csr_addr == MEPC) ? mepc_q :
                  (bus.csr_addr == MCAUSE) ? mcause_q : 32'h0;
        impl    = (bus.csr_addr == MTVEC) || (bus.csr_addr == MEPC) || (bus.csr_addr == MCAUSE);
`ifdef RIP_CSR_MCYCLE_EN
        old_val = (bus.csr_addr == MCYCLE) ? mcycle_q[31:0] :
                  (bus.csr_addr == MCYCLEH) ? mcycle_q[63:32] : old_val;
        impl    = impl || (bus.csr_addr == MCYCLE) || (bus.csr_addr == MCYCLEH);
`endif
        new_val = (bus.csr_op == 2'b01) ? bus.csr_wdata :
                  (bus.csr_op == 2'b10) ? (old_val | bus.csr_wdata) : (old_val & ~bus.csr_wdata);
        run        = (state_q == RUN);
        // Fixed priority: exc_illegal > illegal CSR > ecall > mret > CSR access
        take_ill   = run && (bus.exc_illegal || (access && !impl));
        take_ecall = run && !take_ill && bus.exc_ecall;
        take_mret  = run && !take_ill && !bus.exc_ecall && bus.mret;
        take_csr   = run && access && impl && !bus.exc_illegal && !bus.exc_ecall && !bus.mret;
        // RS/RC with a zero mask must not write (matters for read-only-style reads)
        wr         = take_csr && ((bus.csr_op == 2'b01) || (bus.csr_wdata != 32'h0));
`ifdef RIP_CSR_MCYCLE_EN
        mcycle_d = (wr && bus.csr_addr == MCYCLE)  ? {mcycle_q[63:32], new_val} :
                   (wr && bus.csr_addr == MCYCLEH) ? {new_val, mcycle_q[31:0]} : mcycle_q + 64'd1;
`endif
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q           <= RUN;
            mtvec_q           <= 32'h0;
            mepc_q            <= 32'h0;
            mcause_q          <= 32'h0;
            csr_rdata_q       <= 32'h0;
            csr_rdata_valid_q <= 1'b0;
            redirect_valid_q  <= 1'b0;
            redirect_pc_q     <= RESET_PC;
`ifdef RIP_CSR_MCYCLE_EN
            mcycle_q          <= 64'h0;
`endif
        end else begin
            state_q           <= (take_ill || take_ecall || take_mret) ? FLUSH : RUN;
            csr_rdata_valid_q <= take_csr;
            redirect_valid_q  <= take_ill || take_ecall || take_mret;
            if (take_ill || take_ecall) begin
                mepc_q        <= {bus.inst_pc[31:2], 2'b00};
                mcause_q      <= take_ill ? CAUSE_ILLEGAL_INST : CAUSE_ECALL;
                redirect_pc_q <= mtvec_q;
            end
            if (take_mret) redirect_pc_q <= mepc_q;
            if (take_csr) csr_rdata_q <= old_val;
            if (wr && bus.csr_addr == MTVEC) mtvec_q <= {new_val[31:2], 2'b00};
            if (wr && bus.csr_addr == MEPC) mepc_q <= {new_val[31:2], 2'b00};
            if (wr && bus.csr_addr == MCAUSE) mcause_q <= new_val;
`ifdef RIP_CSR_MCYCLE_EN
            mcycle_q <= mcycle_d;
`endif
        end
    end
    assign bus.csr_rdata       = csr_rdata_q;
    assign bus.csr_rdata_valid = csr_rdata_valid_q;
    assign bus.redirect_valid  = redirect_valid_q;
    assign bus.redirect_pc     = redirect_pc_q;
    assign bus.busy            = (state_q == FLUSH);
endmodule

// File: tb/tb_rip_csr_trap_unit.sv
// tb_rip_csr_trap_unit: directed scoreboard bench for rip_csr_trap_unit.
module tb_rip_csr_trap_unit;
    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   failures = 0;
    always #5 clk = ~clk;
    rip_csr_trap_unit_if bus ();
    rip_csr_trap_unit #(.RESET_PC(32'h0)) dut (.clk(clk), .rstn(rstn), .bus(bus));
    typedef struct {
        logic        dv;
        logic        crd;
        logic [31:0] rd;
        logic        rv;
        logic [31:0] rpc;
        logic        bz;
    } exp_t;
    exp_t q[$];
    function automatic exp_t E(logic dv, logic [31:0] rd, logic rv, logic [31:0] rpc, logic bz);
        exp_t e;
        e.dv = dv; e.crd = dv; e.rd = rd; e.rv = rv; e.rpc = rpc; e.bz = bz;
        return e;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic step(input string tag, input logic v, input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] w, input logic [31:0] pc, input logic il, input logic ec,
                        input logic mr, input exp_t e);
        exp_t g;
        bus.csr_valid = v; bus.csr_op = op; bus.csr_addr = a; bus.csr_wdata = w;
        bus.inst_pc = pc; bus.exc_illegal = il; bus.exc_ecall = ec; bus.mret = mr;
        q.push_back(e);
        @(posedge clk);
        #1;
        g = q.pop_front();
        chk({tag, ".dv"}, {31'b0, bus.csr_rdata_valid}, {31'b0, g.dv});
        chk({tag, ".rv"}, {31'b0, bus.redirect_valid}, {31'b0, g.rv});
        chk({tag, ".busy"}, {31'b0, bus.busy}, {31'b0, g.bz});
        if (g.crd) chk({tag, ".rdata"}, bus.csr_rdata, g.rd);
        if (g.rv) chk({tag, ".rpc"}, bus.redirect_pc, g.rpc);
    endtask
    task automatic idle(input string tag, input exp_t e);
        step(tag, 1'b0, 2'b00, 12'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, e);
    endtask
    exp_t nil, fl;
    initial begin
        nil = E(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        rstn = 1'b0;
        bus.csr_valid = 1'b0; bus.csr_op = 2'b00; bus.csr_addr = 12'h0; bus.csr_wdata = 32'h0;
        bus.inst_pc = 32'h0; bus.exc_illegal = 1'b0; bus.exc_ecall = 1'b0; bus.mret = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.rdata", bus.csr_rdata, 32'h0);
        chk("rst.dv", {31'b0, bus.csr_rdata_valid}, 32'h0);
        chk("rst.rv", {31'b0, bus.redirect_valid}, 32'h0);
        chk("rst.rpc", bus.redirect_pc, 32'h0);
        chk("rst.busy", {31'b0, bus.busy}, 32'h0);
        rstn = 1'b1;
        step("rw_mtvec", 1, 2'b01, 12'h305, 32'h1003, 0, 0, 0, 0, E(1, 32'h0, 0, 0, 0));
        step("rd_mtvec", 1, 2'b10, 12'h305, 32'h0, 0, 0, 0, 0, E(1, 32'h1000, 0, 0, 0));
        step("rw_mtvec2", 1, 2'b01, 12'h305, 32'h100, 0, 0, 0, 0, E(1, 32'h1000, 0, 0, 0));
        step("ecall", 0, 2'b00, 12'h0, 32'h0, 32'h44, 0, 1, 0, E(0, 0, 1, 32'h100, 1));
        step("flush_ign", 1, 2'b01, 12'h341, 32'h999, 0, 0, 0, 0, nil);
        step("rd_mepc", 1, 2'b10, 12'h341, 32'h0, 0, 0, 0, 0, E(1, 32'h44, 0, 0, 0));
        step("rd_mcause", 1, 2'b10, 12'h342, 32'h0, 0, 0, 0, 0, E(1, 32'd11, 0, 0, 0));
        step("ill_ecall", 1, 2'b01, 12'h341, 32'h200, 32'h83, 1, 1, 0, E(0, 0, 1, 32'h100, 1));
        idle("flush1", nil);
        step("rd_mepc2", 1, 2'b10, 12'h341, 32'h0, 0, 0, 0, 0, E(1, 32'h80, 0, 0, 0));
        step("rd_mcause2", 1, 2'b11, 12'h342, 32'h0, 0, 0, 0, 0, E(1, 32'd2, 0, 0, 0));
        step("mret", 0, 2'b00, 12'h0, 32'h0, 0, 0, 0, 1, E(0, 0, 1, 32'h80, 1));
        step("flush_csr", 1, 2'b01, 12'h342, 32'h55, 0, 0, 0, 0, nil);
        step("rs_zero", 1, 2'b10, 12'h342, 32'h0, 0, 0, 0, 0, E(1, 32'd2, 0, 0, 0));
        step("rc_all", 1, 2'b11, 12'h342, 32'hFFFF_FFFF, 0, 0, 0, 0, E(1, 32'd2, 0, 0, 0));
        step("rd_mcause3", 1, 2'b10, 12'h342, 32'h0, 0, 0, 0, 0, E(1, 32'h0, 0, 0, 0));
        step("rw_mepc", 1, 2'b01, 12'h341, 32'h203, 0, 0, 0, 0, E(1, 32'h80, 0, 0, 0));
        step("rd_mepc3", 1, 2'b10, 12'h341, 32'h0, 0, 0, 0, 0, E(1, 32'h200, 0, 0, 0));
        step("ill_csr", 1, 2'b01, 12'h7C0, 32'h1, 32'h30, 0, 0, 0, E(0, 0, 1, 32'h100, 1));
        idle("flush2", nil);
        step("rd_mcause4", 1, 2'b10, 12'h342, 32'h0, 0, 0, 0, 0, E(1, 32'd2, 0, 0, 0));
        step("rd_mepc4", 1, 2'b10, 12'h341, 32'h0, 0, 0, 0, 0, E(1, 32'h30, 0, 0, 0));
        step("mret_csr", 1, 2'b01, 12'h305, 32'h4000, 0, 0, 0, 1, E(0, 0, 1, 32'h30, 1));
        idle("flush3", nil);
        step("ecall_mret", 0, 2'b00, 12'h0, 32'h0, 32'h60, 0, 1, 1, E(0, 0, 1, 32'h100, 1));
        idle("flush4", nil);
        step("rd_mepc5", 1, 2'b10, 12'h341, 32'h0, 0, 0, 0, 0, E(1, 32'h60, 0, 0, 0));
        step("rw_mcause", 1, 2'b01, 12'h342, 32'h0, 0, 0, 0, 0, E(1, 32'd11, 0, 0, 0));
`ifdef RIP_CSR_MCYCLE_EN
        fl = E(1, 32'h0, 0, 0, 0);
        fl.crd = 1'b0;
        step("wr_mcycle", 1, 2'b01, 12'hB00, 32'hFFFF_FFFF, 0, 0, 0, 0, fl);
        step("rd_mcycle", 1, 2'b10, 12'hB00, 32'h0, 0, 0, 0, 0, E(1, 32'hFFFF_FFFF, 0, 0, 0));
        step("rd_mcycleh", 1, 2'b10, 12'hB80, 32'h0, 0, 0, 0, 0, E(1, 32'h1, 0, 0, 0));
`else
        fl = nil;
        step("mcycle_ill", 1, 2'b10, 12'hB00, 32'h0, 32'h10, 0, 0, 0, E(0, 0, 1, 32'h100, 1));
        idle("flush5", fl);
        step("rd_mcause5", 1, 2'b10, 12'h342, 32'h0, 0, 0, 0, 0, E(1, 32'd2, 0, 0, 0));
        step("rd_mepc6", 1, 2'b10, 12'h341, 32'h0, 0, 0, 0, 0, E(1, 32'h10, 0, 0, 0));
`endif
        rstn = 1'b0;
        idle("rst2", nil);
        chk("rst2.rpc", bus.redirect_pc, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rip_csr_trap_unit.md
Name: rip_csr_trap_unit

Overview:
- Machine-mode CSR file and trap sequencer for the RIP core. Holds mtvec (0x305), mepc (0x341) and mcause (0x342), and executes CSRRW/CSRRS/CSRRC.
- Takes illegal-instruction and ecall exceptions and mret from decode/execute, and issues a one-cycle PC redirect to the fetch stage.
- Cause codes: CAUSE_ILLEGAL_INST=2, CAUSE_ECALL=11, from rip_config.

Parameters:
- RESET_PC, 32'h0, redirect_pc value after reset (rip_config START_ADDR).

Ports:
- clk  in  1  core clock
- rstn  in  1  reset: synchronous, active-low
- csr_valid  in  1  CSR instruction present this cycle
- csr_op  in  2  01=RW, 10=RS, 11=RC, 00=no-op (treated as csr_valid=0)
- csr_addr  in  12  CSR address
- csr_wdata  in  32  rs1 value or zero-extended zimm, already resolved
- inst_pc  in  32  PC of the instruction presented this cycle
- exc_illegal  in  1  decode flagged illegal instruction
- exc_ecall  in  1  ecall executed
- mret  in  1  mret executed
- csr_rdata  out  32  old CSR value, registered
- csr_rdata_valid  out  1  pulse: csr_rdata valid
- redirect_valid  out  1  pulse: fetch must jump to redirect_pc and flush younger instructions
- redirect_pc  out  32  redirect target
- busy  out  1  high in FLUSH; upstream must hold/discard inputs

Behaviour:
- Reset (rstn=0 at posedge) clears all state:
  - mtvec=0, mepc=0, mcause=0, csr_rdata=0
  - csr_rdata_valid=0, redirect_valid=0, busy=0
  - redirect_pc=RESET_PC, state=RUN
  - Any trap in flight is discarded.
- FSM states: RUN and FLUSH.
  - RUN -> FLUSH when a trap or mret is accepted.
  - FLUSH -> RUN after exactly one cycle.
  - In FLUSH, all inputs are ignored (no CSR write, no trap, no read pulse).
- Event priority in RUN, highest first:
  1. exc_illegal
  2. internal illegal CSR access
  3. exc_ecall
  4. mret
  5. CSR access
  - Only the winning event takes effect; lower events in the same cycle are dropped, including their CSR writes.
- Internal illegal CSR access: csr_valid with an unimplemented csr_addr.
- Trap entry, accepted in cycle N:
  - mepc <= {inst_pc[31:2],2'b00}
  - mcause <= 2 (illegal) or 11 (ecall)
  - Cycle N+1: redirect_valid=1, redirect_pc={mtvec[31:2],2'b00}, busy=1.
  - Uses the mtvec value held before cycle N.
- mret accepted in N: cycle N+1 has redirect_valid=1, redirect_pc=mepc, busy=1; no CSR changes.
- CSR access accepted in N:
  - Cycle N+1: csr_rdata = pre-write value, csr_rdata_valid=1.
  - Write committed at the end of cycle N: RW new=wdata; RS new=old|wdata; RC new=old&~wdata.
  - RS/RC with csr_wdata==0 performs no write.
- Field rules: mtvec[1:0] and mepc[1:0] always read 0 (direct mode only; written low bits ignored); mcause is fully writable.
- Latencies: CSR read 1 cycle; trap/mret to redirect 1 cycle; back-to-back CSR accesses are allowed every cycle in RUN.
- A CSR write to mtvec in cycle N affects a trap accepted in cycle N+1 or later.

Optional Feature:
- Macro: RIP_CSR_MCYCLE_EN.
- When defined:
  - 64-bit mcycle counter increments every cycle outside reset and wraps 2^64-1 -> 0.
  - Readable/writable at 0xB00 (low 32) and 0xB80 (high 32).
  - In a cycle where one half is written, the written value is loaded and the counter does not increment; the other half holds.
  - Reset value is 0.
- When undefined: 0xB00/0xB80 are unimplemented and raise the internal illegal trap; no counter logic.

Test Plan:
- Reset, then CSRRW mtvec=0x0000_1003 -> next cycle csr_rdata=0, csr_rdata_valid=1; subsequent read of mtvec returns 0x0000_1000.
- mtvec=0x100, exc_ecall with inst_pc=0x44 -> next cycle redirect_valid=1, redirect_pc=0x100, busy=1; mepc=0x44, mcause=11; RUN resumes the following cycle.
- exc_illegal and exc_ecall together, inst_pc=0x80 -> mcause=2, mepc=0x80; a CSRRW mepc=0x200 presented in the same cycle is not written (mepc stays 0x80).
- mret after the illegal trap above -> redirect_pc=0x80; a CSR access presented during FLUSH produces no csr_rdata_valid and no write.
- CSRRS mcause with wdata=0 -> csr_rdata=old value, no write; CSRRC mcause 0xFFFF_FFFF -> mcause=0; access to 0x7C0 -> redirect to mtvec, mcause=2, mepc=inst_pc.
- With RIP_CSR_MCYCLE_EN: write 0xFFFF_FFFF to 0xB00 -> after 1 cycle low=0 and high=1. Without the macro: read 0xB00 -> illegal trap, mcause=2.
